// File: rtl/ft245_tx_pkg.sv
// Shared constants and types for the FT245 synchronous-mode transmit stage.
// Holds the frame sync bytes, the FSM state encoding and the byte-count helper.
package ft245_tx_pkg;

  localparam logic [7:0] SYNC0 = 8'hA5;
  localparam logic [7:0] SYNC1 = 8'h5A;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR0 = 2'd1,
    ST_HDR1 = 2'd2,
    ST_DATA = 2'd3
  } tx_state_e;

  // Bytes needed to carry one FFT word, MSB zero-extended to a byte boundary.
  function automatic int nbytes(input int width);
    return (width + 7) / 8;
  endfunction

endpackage

// File: rtl/ft245_tx_if.sv
// Word-input and FT245 bus bundle for ft245_tx.
// The slave modport is the transmitter; the master modport is the FFT/FTDI environment.
interface ft245_tx_if #(
  parameter int DATA_WIDTH = 24
);

  logic [DATA_WIDTH-1:0] din;
  logic                  din_valid;
  logic                  din_last;
  logic                  ft_txe_n;
  logic                  ft_wr_n;
  logic [7:0]            ft_data;
  logic                  ft245_empty;
  logic                  overflow;

  modport master (
    output din,
    output din_valid,
    output din_last,
    output ft_txe_n,
    input  ft_wr_n,
    input  ft_data,
    input  ft245_empty,
    input  overflow
  );

  modport slave (
    input  din,
    input  din_valid,
    input  din_last,
    input  ft_txe_n,
    output ft_wr_n,
    output ft_data,
    output ft245_empty,
    output overflow
  );

endinterface

// File: rtl/ft245_tx_word_fifo.sv
// Synchronous word FIFO with a registered read port that always holds the head entry.
// The caller must only push when not full or when popping in the same cycle.
module ft245_tx_word_fifo #(
  parameter int WIDTH = 25,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_q;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;

  always_comb begin
    wr_ptr_d = push_i ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_i  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push_i && !pop_i) begin
      count_d = count_q + (AW+1)'(1);
    end else if (!push_i && pop_i) begin
      count_d = count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Read the next head address; forward the write when it lands on that slot
  // (empty buffer, or a single entry being replaced in the same cycle).
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem[wr_ptr_q] <= wr_data_i;
    end
    if (push_i && (wr_ptr_q == rd_ptr_d)) begin
      rd_data_q <= wr_data_i;
    end else begin
      rd_data_q <= mem[rd_ptr_d];
    end
  end

  assign rd_data_o = rd_data_q;
  assign full_o    = count_q[AW];
  assign empty_o   = (count_q == '0);

endmodule

// File: rtl/ft245_tx.sv
// FT245 synchronous-mode transmitter: buffers FFT words, frames them with a
// two-byte sync header and streams them MSB byte first to the FT2232H.
module ft245_tx
  import ft245_tx_pkg::*;
#(
  parameter int DATA_WIDTH     = 24,
  parameter int BUF_ADDR_WIDTH = 4
) (
  input logic         clk,
  input logic         rst_n,
  ft245_tx_if.slave   tx_if
);

  localparam int NBYTES = nbytes(DATA_WIDTH);
  localparam int SR_W   = NBYTES * 8;
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int FW     = DATA_WIDTH + 1;

  tx_state_e        state_q;
  logic             frame_open_q;
  logic             last_q;
  logic             overflow_q;
  logic [7:0]       ft_data_q;
  logic [SR_W-1:0]  shreg_q;
  logic [CNT_W-1:0] cnt_q;

  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             xfer;
  logic             final_byte;
  logic [FW-1:0]    rd_word;
  logic [SR_W-1:0]  rd_ext;

  ft245_tx_word_fifo #(
    .WIDTH (FW),
    .AW    (BUF_ADDR_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (push),
    .wr_data_i ({tx_if.din_last, tx_if.din}),
    .pop_i     (pop),
    .rd_data_o (rd_word),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // A byte is pending in every non-idle state, so a transfer is simply "not idle and TXE low".
  assign xfer       = (state_q != ST_IDLE) && !tx_if.ft_txe_n;
  assign final_byte = (cnt_q == '0);
  assign rd_ext     = SR_W'(rd_word[DATA_WIDTH-1:0]);

  always_comb begin
    pop = 1'b0;
    case (state_q)
      ST_IDLE: pop = !fifo_empty && frame_open_q;
      ST_HDR1: pop = xfer;
      ST_DATA: pop = xfer && final_byte && !last_q && !fifo_empty;
      default: pop = 1'b0;
    endcase
  end

  // A pop frees a slot this cycle, so a full buffer can still take a word alongside it.
  assign push = tx_if.din_valid && (!fifo_full || pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      frame_open_q <= 1'b0;
      last_q       <= 1'b0;
      ft_data_q    <= '0;
      shreg_q      <= '0;
      cnt_q        <= '0;
    end else if (pop) begin
      ft_data_q    <= rd_ext[SR_W-1 -: 8];
      shreg_q      <= rd_ext << 8;
      cnt_q        <= CNT_W'(NBYTES - 1);
      last_q       <= rd_word[DATA_WIDTH];
      frame_open_q <= 1'b1;
      state_q      <= ST_DATA;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state_q   <= ST_HDR0;
            ft_data_q <= SYNC0;
          end
        end
        ST_HDR0: begin
          if (xfer) begin
            state_q   <= ST_HDR1;
            ft_data_q <= SYNC1;
          end
        end
        ST_DATA: begin
          if (xfer) begin
            if (!final_byte) begin
              ft_data_q <= shreg_q[SR_W-1 -: 8];
              shreg_q   <= shreg_q << 8;
              cnt_q     <= cnt_q - CNT_W'(1);
            end else begin
              // Final byte without a follow-on pop: close the frame or go idle.
              if (last_q) begin
                frame_open_q <= 1'b0;
              end
              if (fifo_empty) begin
                state_q <= ST_IDLE;
              end else if (last_q) begin
                state_q   <= ST_HDR0;
                ft_data_q <= SYNC0;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else if (tx_if.din_valid && fifo_full && !pop) begin
      overflow_q <= 1'b1;
    end
  end

  assign tx_if.ft_wr_n     = !xfer;
  assign tx_if.ft_data     = ft_data_q;
  assign tx_if.ft245_empty = (state_q == ST_IDLE) && fifo_empty;
  assign tx_if.overflow    = overflow_q;

endmodule

// File: tb/tb_ft245_tx.sv
// Directed bench for ft245_tx: framing, stalls, back-to-back frames, overflow,
// reset mid-frame and full-buffer push+pop, with hand-written expected byte streams.
module tb_ft245_tx;

  localparam int DW = 24;
  localparam int AW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  ft245_tx_if #(.DATA_WIDTH(DW)) bus();

  ft245_tx #(
    .DATA_WIDTH     (DW),
    .BUF_ADDR_WIDTH (AW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tx_if (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  // Record every byte that will be taken on the coming rising edge.
  always @(negedge clk) begin
    if (rst_n && !bus.ft_wr_n) got_q.push_back(bus.ft_data);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_word(input logic [23:0] w, input logic l);
    step();
    bus.din       = w;
    bus.din_valid = 1'b1;
    bus.din_last  = l;
    $display("push %06h last=%0b", w, l);
  endtask

  task automatic idle();
    step();
    bus.din_valid = 1'b0;
    bus.din_last  = 1'b0;
  endtask

  task automatic wait_bytes(input int n, input string tag);
    int cyc = 0;
    while (got_q.size() < n && cyc < 400) begin
      @(posedge clk);
      #2;
      cyc++;
    end
    chk({tag, "_timeout"}, 32'(got_q.size() >= n), 32'd1);
  endtask

  task automatic exp_hdr();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
  endtask

  task automatic exp_word(input logic [23:0] w);
    exp_q.push_back(w[23:16]);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
  endtask

  task automatic compare_bytes(input string tag);
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk($sformatf("%s_b%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    end
    $display("%s: %0d bytes received, %0d expected", tag, got_q.size(), exp_q.size());
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_empty_rise(input string tag);
    @(negedge clk);
    chk({tag, "_empty_rise"}, 32'(bus.ft245_empty), 32'd1);
    repeat (3) step();
  endtask

  initial begin
    bus.din       = '0;
    bus.din_valid = 1'b0;
    bus.din_last  = 1'b0;
    bus.ft_txe_n  = 1'b0;
    rst_n         = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;

    @(negedge clk);
    chk("rst_wr_n",     32'(bus.ft_wr_n),     32'd1);
    chk("rst_data",     32'(bus.ft_data),     32'h00);
    chk("rst_overflow", 32'(bus.overflow),    32'd0);
    chk("rst_empty",    32'(bus.ft245_empty), 32'd1);

    // Basic frame plus push-to-SYNC0 latency.
    drive_word(24'h123456, 1'b0);
    drive_word(24'hABCDEF, 1'b1);
    @(negedge clk);
    chk("t1_empty_fall", 32'(bus.ft245_empty), 32'd0);
    chk("t1_wr_n_t1",    32'(bus.ft_wr_n),     32'd1);
    idle();
    @(negedge clk);
    chk("t1_lat_wr_n", 32'(bus.ft_wr_n), 32'd0);
    chk("t1_lat_data", 32'(bus.ft_data), 32'hA5);
    exp_hdr(); exp_word(24'h123456); exp_word(24'hABCDEF);
    wait_bytes(8, "t1");
    check_empty_rise("t1");
    compare_bytes("t1");

    // Stall while byte 34 is on the bus.
    drive_word(24'h123456, 1'b0);
    drive_word(24'hABCDEF, 1'b1);
    idle();
    exp_hdr(); exp_word(24'h123456); exp_word(24'hABCDEF);
    wait_bytes(3, "t2a");
    bus.ft_txe_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("t2_stall_wr_n%0d", i), 32'(bus.ft_wr_n), 32'd1);
      chk($sformatf("t2_stall_data%0d", i), 32'(bus.ft_data), 32'h34);
    end
    step();
    bus.ft_txe_n = 1'b0;
    wait_bytes(8, "t2b");
    check_empty_rise("t2");
    compare_bytes("t2");

    // Two single-word frames back to back.
    drive_word(24'h000001, 1'b1);
    drive_word(24'h000002, 1'b1);
    idle();
    exp_hdr(); exp_word(24'h000001); exp_hdr(); exp_word(24'h000002);
    wait_bytes(10, "t3");
    check_empty_rise("t3");
    compare_bytes("t3");

    // Overflow: 17 pushes into a stalled 16-deep buffer.
    step();
    bus.ft_txe_n = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      drive_word(24'(i), (i >= 16));
    end
    @(negedge clk);
    chk("t4_ovf_before", 32'(bus.overflow), 32'd0);
    idle();
    @(negedge clk);
    chk("t4_ovf_set",   32'(bus.overflow),    32'd1);
    chk("t4_not_empty", 32'(bus.ft245_empty), 32'd0);
    chk("t4_stall",     32'(bus.ft_wr_n),     32'd1);
    exp_hdr();
    for (int i = 1; i <= 16; i++) exp_word(24'(i));
    step();
    bus.ft_txe_n = 1'b0;
    wait_bytes(50, "t4");
    check_empty_rise("t4");
    compare_bytes("t4");
    chk("t4_ovf_sticky", 32'(bus.overflow), 32'd1);

    // Reset after byte 12 of a frame.
    drive_word(24'h123456, 1'b1);
    idle();
    wait_bytes(3, "t5a");
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_rst_wr_n",     32'(bus.ft_wr_n),     32'd1);
    chk("t5_rst_data",     32'(bus.ft_data),     32'h00);
    chk("t5_rst_overflow", 32'(bus.overflow),    32'd0);
    chk("t5_rst_empty",    32'(bus.ft245_empty), 32'd1);
    got_q.delete();
    drive_word(24'h000009, 1'b1);
    idle();
    exp_hdr(); exp_word(24'h000009);
    wait_bytes(5, "t5b");
    check_empty_rise("t5");
    compare_bytes("t5");

    // Full buffer: push lands in the same cycle as the HDR1 pop.
    step();
    bus.ft_txe_n = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      drive_word(24'h000100 + 24'(i), 1'b0);
    end
    step();
    bus.din_valid = 1'b0;
    bus.ft_txe_n  = 1'b0;
    drive_word(24'hBEEF17, 1'b1);
    @(negedge clk);
    chk("t6_pop_data", 32'(bus.ft_data), 32'h5A);
    chk("t6_pop_wr_n", 32'(bus.ft_wr_n), 32'd0);
    idle();
    @(negedge clk);
    chk("t6_no_ovf", 32'(bus.overflow), 32'd0);
    exp_hdr();
    for (int i = 1; i <= 16; i++) exp_word(24'h000100 + 24'(i));
    exp_word(24'hBEEF17);
    wait_bytes(53, "t6");
    check_empty_rise("t6");
    compare_bytes("t6");
    chk("t6_no_ovf_end", 32'(bus.overflow), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
